axi_ar_decoder_tracked: RTL

AXI_AR_DECODER_TRACKED -- requirements
Module: axi_ar_decoder_tracked

---
 rtl/axi_ar_decoder_tracked.sv | 109 ++++++++++
 1 files changed

// File: rtl/axi_ar_decoder_tracked.sv
// axi_ar_decoder_tracked: AXI read-address decoder with outstanding-read tracking and decode-error flow.
// Define AXI_AR_DEC_MULTIHIT_ERR_EN to turn overlapping target hits into decode errors.
module axi_ar_decoder_tracked #(
  parameter int ADDR_WIDTH  = 32,
  parameter int N_INIT_PORT = 8,
  parameter int N_REGION    = 4,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     arvalid_i,
  output logic                                     arready_o,
  input  logic [ADDR_WIDTH-1:0]                    araddr_i,
  output logic [N_INIT_PORT-1:0]                   arvalid_o,
  input  logic [N_INIT_PORT-1:0]                   arready_i,
  input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] start_addr_i,
  input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] end_addr_i,
  input  logic [N_REGION*N_INIT_PORT-1:0]          enable_region_i,
  input  logic [N_INIT_PORT-1:0]                   connectivity_map_i,
  input  logic                                     r_done_i,
  output logic                                     error_req_o,
  input  logic                                     error_gnt_i,
  output logic                                     sample_ardata_info_o,
  output logic [N_INIT_PORT-1:0]                   target_o,
  output logic [CNT_WIDTH-1:0]                     outstanding_o
);
  localparam logic [1:0] OPERATIVE = 2'd0;
  localparam logic [1:0] ERR_DRAIN = 2'd1;
  localparam logic [1:0] ERR_REQ   = 2'd2;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [1:0]             state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [N_INIT_PORT-1:0] tgt_q, tgt_d, hit, raw_hit, sel;
  logic                   dec_err, stall, inc, dec;

  // region bounds are packed region-major: entry (r*N_INIT_PORT + p)
  always_comb begin
    raw_hit = '0;
    for (int p = 0; p < N_INIT_PORT; p++)
      for (int r = 0; r < N_REGION; r++)
        if (enable_region_i[r*N_INIT_PORT+p] &&
            araddr_i >= start_addr_i[(r*N_INIT_PORT+p)*ADDR_WIDTH +: ADDR_WIDTH] &&
            araddr_i <= end_addr_i[(r*N_INIT_PORT+p)*ADDR_WIDTH +: ADDR_WIDTH])
          raw_hit[p] = 1'b1;
  end

  assign hit = raw_hit & connectivity_map_i;
  assign sel = hit & (~hit + N_INIT_PORT'(1));

`ifdef AXI_AR_DEC_MULTIHIT_ERR_EN
  assign dec_err = (hit == '0) || ((hit & (hit - N_INIT_PORT'(1))) != '0);
`else
  assign dec_err = hit == '0;
`endif

  assign stall = cnt_q == CNT_MAX || (cnt_q != '0 && sel != tgt_q);

  always_comb begin
    state_d              = state_q;
    arready_o            = 1'b0;
    arvalid_o            = '0;
    error_req_o          = 1'b0;
    sample_ardata_info_o = 1'b0;
    case (state_q)
      OPERATIVE:
        if (arvalid_i && dec_err) begin
          arready_o            = 1'b1;
          sample_ardata_info_o = 1'b1;
          state_d              = ERR_DRAIN;
        end else if (arvalid_i && !stall) begin
          arvalid_o = sel;
          arready_o = |(sel & arready_i);
        end
      ERR_DRAIN: state_d = cnt_q == '0 ? ERR_REQ : ERR_DRAIN;
      ERR_REQ: begin
        error_req_o = 1'b1;
        state_d     = error_gnt_i ? OPERATIVE : ERR_REQ;
      end
      default: state_d = OPERATIVE;
    endcase
    if (!rst_n) begin
      arready_o            = 1'b0;
      arvalid_o            = '0;
      error_req_o          = 1'b0;
      sample_ardata_info_o = 1'b0;
    end
  end

  assign inc   = |(arvalid_o & arready_i);
  assign dec   = r_done_i && cnt_q != '0;
  assign cnt_d = cnt_q + CNT_WIDTH'(inc) - CNT_WIDTH'(dec);
  assign tgt_d = inc ? sel : (cnt_d == '0 ? '0 : tgt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OPERATIVE;
      cnt_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

  assign outstanding_o = cnt_q;
  assign target_o      = tgt_q;
endmodule
